// File: rtl/demo_pkg.sv
// Shared constants for the demo layer pipeline: VGA 640x480@60 timing and tile-space coordinate widths.
// The sine layer and its siblings import X_W/Y_W from here so that they match the scanner.
package demo_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  localparam int X_W = 6;
  localparam int Y_W = 5;
  localparam int DEF_CELL_W    = 10;
  localparam int DEF_CELL_H    = 16;
  localparam int DEF_DN_FRAMES = 256;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/layer_scanner_if.sv
// Scanner-to-layer bundle: scroll controls in, sync/enable/coordinates out.
// master is the scanner side; slave is the consumer that drives scroll controls.
interface layer_scanner_if;
  logic                      scroll_en;
  logic [2:0]                scroll_step;
  logic                      hsync;
  logic                      vsync;
  logic                      de;
  logic [demo_pkg::X_W-1:0]  x;
  logic [demo_pkg::Y_W-1:0]  y;
  logic                      daynight;
  logic                      frame_tick;

  modport master (
    input  scroll_en, scroll_step,
    output hsync, vsync, de, x, y, daynight, frame_tick
  );

  modport slave (
    output scroll_en, scroll_step,
    input  hsync, vsync, de, x, y, daynight, frame_tick
  );
endinterface

// File: rtl/vga_timing.sv
// Raster position counters with combinational decode of the current position.
// Decoded flags describe the position held this cycle; the caller registers them.
module vga_timing
  import demo_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic de,
  output logic hsync,
  output logic vsync,
  output logic h_act,
  output logic line_end,
  output logic frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS = H_ACTIVE + H_FP;
  localparam int H_SE = H_SS + H_SYNC - 1;
  localparam int V_SS = V_ACTIVE + V_FP;
  localparam int V_SE = V_SS + V_SYNC - 1;
  localparam int HW = cnt_w(H_TOTAL);
  localparam int VW = cnt_w(V_TOTAL);

  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (line_end) begin
      hpos <= '0;
      vpos <= frame_end ? '0 : vpos + VW'(1);
    end else begin
      hpos <= hpos + HW'(1);
    end
  end

  assign line_end  = (hpos == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (vpos == VW'(V_TOTAL - 1));
  assign h_act     = (hpos < HW'(H_ACTIVE));
  assign de        = h_act && (vpos < VW'(V_ACTIVE));
  assign hsync     = !((hpos >= HW'(H_SS)) && (hpos <= HW'(H_SE)));
  assign vsync     = !((vpos >= VW'(V_SS)) && (vpos <= VW'(V_SE)));
endmodule

// File: rtl/layer_scanner.sv
// Raster source for the colour layers: scrolled cell coordinates, syncs and day/night flag.
// One registered stage, every output describes the same pixel; free-running, no backpressure.
module layer_scanner
  import demo_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int CELL_H    = DEF_CELL_H,
  parameter int DN_FRAMES = DEF_DN_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  layer_scanner_if.master  bus
);
  localparam int CW = cnt_w(CELL_W);
  localparam int RW = cnt_w(CELL_H);
  localparam logic [7:0] DN_LAST = 8'(DN_FRAMES - 1);

  logic de_raw, hsync_raw, vsync_raw, h_act, line_end, frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .de        (de_raw),
    .hsync     (hsync_raw),
    .vsync     (vsync_raw),
    .h_act     (h_act),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  logic [CW-1:0]  csub;
  logic [X_W-1:0] col;
  logic [RW-1:0]  rsub;
  logic [Y_W-1:0] row;
  logic [X_W-1:0] scroll_x;
  logic [7:0]     fcount;
  logic           dn_state;

  // Cell counters always describe the position the timing counters hold this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csub     <= '0;
      col      <= '0;
      rsub     <= '0;
      row      <= '0;
      scroll_x <= '0;
      fcount   <= '0;
      dn_state <= 1'b0;
    end else begin
      if (line_end) begin
        csub <= '0;
        col  <= '0;
      end else if (h_act) begin
        if (csub == CW'(CELL_W - 1)) begin
          csub <= '0;
          col  <= col + X_W'(1);
        end else begin
          csub <= csub + CW'(1);
        end
      end

      if (frame_end) begin
        rsub <= '0;
        row  <= '0;
      end else if (line_end) begin
        if (rsub == RW'(CELL_H - 1)) begin
          rsub <= '0;
          row  <= row + Y_W'(1);
        end else begin
          rsub <= rsub + RW'(1);
        end
      end

      // Scroll controls are only looked at on the last pixel of the frame.
      if (frame_end) begin
        if (bus.scroll_en)
          scroll_x <= scroll_x + X_W'(bus.scroll_step);
        if (fcount == DN_LAST) begin
          fcount   <= '0;
          dn_state <= ~dn_state;
        end else begin
          fcount <= fcount + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hsync      <= 1'b1;
      bus.vsync      <= 1'b1;
      bus.de         <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.daynight   <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.hsync      <= hsync_raw;
      bus.vsync      <= vsync_raw;
      bus.de         <= de_raw;
      bus.x          <= de_raw ? (col + scroll_x) : '0;
      bus.y          <= de_raw ? row : '0;
      bus.daynight   <= dn_state;
      bus.frame_tick <= frame_end;
    end
  end
endmodule
